red_centroid_tracker: RTL

Consumes the filtered RGB444 pixel stream produced by the 2D convolution stage and classifies each pixel as "cape red" or not. It emits a registered 1-bit mask alongside the stream and accumulates count, Σx and Σy of red pixels over each frame. At frame end it computes the integer centroid with a sequential divider and reports it once per frame to the robot control logic.

---
 rtl/centroid_pkg.sv | 42 ++++
 rtl/seq_divider.sv | 78 +++++++
 rtl/red_centroid_tracker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/centroid_pkg.sv
// Shared definitions for the red centroid tracker.
// Contents:
//   - image geometry and classification thresholds
//   - datapath widths for coordinates, counters, sums and the divider
//   - state_t: tracker FSM states
//   - is_red(): "cape red" classification of one RGB444 pixel
package centroid_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int PIXEL_BITS   = 12;
  localparam int RED_MIN      = 8;
  localparam int RED_MARGIN   = 3;
  localparam int MIN_PIXELS   = 27;

  localparam int X_BITS     = 9;
  localparam int Y_BITS     = 8;
  localparam int COUNT_BITS = 17;
  localparam int SUM_BITS   = 25;
  localparam int DIV_CYCLES = 25;
  localparam int CNT_BITS   = 5;   // wide enough to hold DIV_CYCLES-1

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Nibbles are zero-extended to 5 bits so g+margin and b+margin never wrap.
  function automatic logic is_red(input logic [PIXEL_BITS-1:0] pixel);
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
    r = {1'b0, pixel[11:8]};
    g = {1'b0, pixel[7:4]};
    b = {1'b0, pixel[3:0]};
    return (r >= 5'(RED_MIN)) &&
           (r >= g + 5'(RED_MARGIN)) &&
           (r >= b + 5'(RED_MARGIN));
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        one-cycle pulse: load dividend/divisor
//   dividend     SUM_BITS numerator
//   divisor      COUNT_BITS denominator (caller guarantees nonzero)
//   done         one-cycle pulse, DIV_CYCLES cycles after start
//   quotient     SUM_BITS result, final while done is high and held after
// The start edge already performs the first of the SUM_BITS iterations, so
// the quotient is complete in the same cycle that done is raised.
module seq_divider
  import centroid_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SUM_BITS-1:0]   dividend,
  input  logic [COUNT_BITS-1:0] divisor,
  output logic                  done,
  output logic [SUM_BITS-1:0]   quotient
);

  logic [COUNT_BITS-1:0] rem;
  logic [COUNT_BITS-1:0] div_r;
  logic [SUM_BITS-1:0]   quo;
  logic [CNT_BITS-1:0]   cnt;
  logic                  running;

  logic [COUNT_BITS-1:0] step_rem;
  logic [SUM_BITS-1:0]   step_quo;
  logic [COUNT_BITS-1:0] step_div;
  logic [COUNT_BITS:0]   shifted;
  logic [COUNT_BITS-1:0] rem_next;
  logic [SUM_BITS-1:0]   quo_next;

  // One restoring iteration; on start it operates on the fresh operands.
  always_comb begin
    step_rem = start ? '0 : rem;
    step_quo = start ? dividend : quo;
    step_div = start ? divisor : div_r;
    shifted  = {step_rem, step_quo[SUM_BITS-1]};
    if (shifted >= {1'b0, step_div}) begin
      rem_next = COUNT_BITS'(shifted - {1'b0, step_div});
      quo_next = {step_quo[SUM_BITS-2:0], 1'b1};
    end else begin
      rem_next = shifted[COUNT_BITS-1:0];
      quo_next = {step_quo[SUM_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      div_r   <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= rem_next;
      quo     <= quo_next;
      div_r   <= divisor;
      cnt     <= CNT_BITS'(DIV_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt != '0) begin
        rem <= rem_next;
        quo <= quo_next;
        cnt <= cnt - CNT_BITS'(1);
      end else begin
        running <= 1'b0;
      end
    end
  end

  assign done     = running && (cnt == '0);
  assign quotient = quo;

endmodule

// File: rtl/red_centroid_tracker.sv
// Classifies a filtered RGB444 pixel stream as "cape red", emits a registered
// per-pixel mask, accumulates count / sum_x / sum_y of red pixels per frame,
// and at frame end divides to report the integer centroid once per frame.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   pixel_in       RGB444 pixel, R=[11:8] G=[7:4] B=[3:0]
//   pixel_valid    pixel_in valid this cycle
//   frame_start    with pixel_valid: first pixel of frame, coordinate (0,0)
//   frame_end      with pixel_valid: last pixel of frame
//   mask_out       red classification of the previous cycle's pixel
//   mask_valid     pixel_valid delayed one cycle
//   centroid_x/y   centroid of the reported frame (0 when no target)
//   red_count      red pixels in the reported frame
//   target_found   red_count >= MIN_PIXELS for the reported frame
//   result_valid   one-cycle pulse when the four outputs above are new
//   busy           divider running
//   frame_drop     one-cycle pulse: a frame_end arrived while not in ACCUM
// Handshake: pixel stream is valid-only (no backpressure); a pixel is
// consumed on every cycle pixel_valid is high. result_valid and frame_drop
// are single-cycle strobes with no acknowledge.
module red_centroid_tracker
  import centroid_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  input  logic                  frame_end,
  output logic                  mask_out,
  output logic                  mask_valid,
  output logic [X_BITS-1:0]     centroid_x,
  output logic [Y_BITS-1:0]     centroid_y,
  output logic [COUNT_BITS-1:0] red_count,
  output logic                  target_found,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  frame_drop
);

  state_t state;
  state_t state_next;

  logic [X_BITS-1:0]     x_cnt;
  logic [Y_BITS-1:0]     y_cnt;
  logic [COUNT_BITS-1:0] count;
  logic [SUM_BITS-1:0]   sum_x;
  logic [SUM_BITS-1:0]   sum_y;
  logic [COUNT_BITS-1:0] shadow_count;
  logic                  shadow_low;

  logic                  fs;
  logic                  fe;
  logic                  pix_red;
  logic [X_BITS-1:0]     cur_x;
  logic [Y_BITS-1:0]     cur_y;
  logic                  x_wrap;
  logic [X_BITS-1:0]     x_adv;
  logic [Y_BITS-1:0]     y_adv;
  logic [COUNT_BITS-1:0] count_next;
  logic [SUM_BITS-1:0]   sum_x_next;
  logic [SUM_BITS-1:0]   sum_y_next;
  logic                  low_count;
  logic [COUNT_BITS-1:0] div_divisor;

  logic                  start;
  logic                  drop;
  logic                  done_x;
  logic                  done_y;
  logic [SUM_BITS-1:0]   quot_x;
  logic [SUM_BITS-1:0]   quot_y;

  assign fs = pixel_valid && frame_start;
  assign fe = pixel_valid && frame_end;

  // Coordinate and accumulator next values. A frame_start pixel restarts
  // from zero and still contributes itself, so these "next" values are also
  // the final totals when the same pixel carries frame_end.
  always_comb begin
    cur_x      = fs ? '0 : x_cnt;
    cur_y      = fs ? '0 : y_cnt;
    pix_red    = pixel_valid && is_red(pixel_in);
    x_wrap     = (cur_x == X_BITS'(IMAGE_WIDTH - 1));
    x_adv      = x_wrap ? '0 : cur_x + X_BITS'(1);
    y_adv      = (x_wrap && (cur_y != Y_BITS'(IMAGE_HEIGHT - 1))) ?
                 cur_y + Y_BITS'(1) : cur_y;
    count_next = (fs ? '0 : count) + (pix_red ? COUNT_BITS'(1) : '0);
    sum_x_next = (fs ? '0 : sum_x) + (pix_red ? SUM_BITS'(cur_x) : '0);
    sum_y_next = (fs ? '0 : sum_y) + (pix_red ? SUM_BITS'(cur_y) : '0);
    // Small targets still run the full divide so latency never varies.
    low_count   = (count_next < COUNT_BITS'(MIN_PIXELS));
    div_divisor = low_count ? COUNT_BITS'(1) : count_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      count      <= '0;
      sum_x      <= '0;
      sum_y      <= '0;
      mask_out   <= 1'b0;
      mask_valid <= 1'b0;
    end else begin
      mask_out   <= pix_red;
      mask_valid <= pixel_valid;
      if (pixel_valid) begin
        x_cnt <= x_adv;
        y_cnt <= y_adv;
        count <= count_next;
        sum_x <= sum_x_next;
        sum_y <= sum_y_next;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // FSM next state; accumulation above runs independently of the state.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    drop       = 1'b0;
    case (state)
      ACCUM: begin
        if (fe) begin
          start      = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        drop = fe;
        if (done_x && done_y) state_next = REPORT;
      end
      REPORT: begin
        drop       = fe;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  seq_divider u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (sum_x_next),
    .divisor  (div_divisor),
    .done     (done_x),
    .quotient (quot_x)
  );

  seq_divider u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (sum_y_next),
    .divisor  (div_divisor),
    .done     (done_y),
    .quotient (quot_y)
  );

  // Shadows freeze the frame's totals so the next frame can accumulate while
  // dividing; result registers load on the last divide cycle so they are
  // already stable while result_valid (state REPORT) is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_count <= '0;
      shadow_low   <= 1'b0;
      centroid_x   <= '0;
      centroid_y   <= '0;
      red_count    <= '0;
      target_found <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      frame_drop <= drop;
      if (start) begin
        shadow_count <= count_next;
        shadow_low   <= low_count;
      end
      if ((state == DIVIDE) && done_x && done_y) begin
        centroid_x   <= shadow_low ? '0 : X_BITS'(quot_x);
        centroid_y   <= shadow_low ? '0 : Y_BITS'(quot_y);
        red_count    <= shadow_count;
        target_found <= !shadow_low;
      end
    end
  end

  assign result_valid = (state == REPORT);
  assign busy         = (state == DIVIDE);

endmodule
